// File: rtl/reaction_game_ctrl_pkg.sv
// Shared definitions for the reaction-time game controller.
// Holds the FSM state type, the "no record" sentinel, the minimum random
// delay, the LFSR seed and the LFSR step function.
package reaction_game_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_GO,
        ST_RESULT,
        ST_FAILED
    } state_e;

    localparam logic [15:0] NO_RECORD    = 16'hFFFF;
    localparam logic [15:0] MIN_DELAY_MS = 16'd1000;
    localparam logic [15:0] LFSR_SEED    = 16'hACE1;

    // x^16 + x^14 + x^13 + x^11 + 1 in right-shifting Fibonacci form.
    // Maximal length, so a nonzero seed never reaches all-zero.
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
    endfunction

endpackage

// File: rtl/reaction_game_ctrl_if.sv
// Player/display bus of the reaction-time game controller.
//   btn_press    : 1-cycle pulse from the debounced player button
//   clr_best     : 1-cycle pulse that erases the best record
//   go_led       : "react now" stimulus
//   fail         : FAILED-state flag for the display
//   current_time : last or running reaction time in ms
//   best_time    : best record in ms, 16'hFFFF when no record exists
// slave = the controller, master = the board/testbench side.
interface reaction_game_ctrl_if;

    logic        btn_press;
    logic        clr_best;
    logic        go_led;
    logic        fail;
    logic [15:0] current_time;
    logic [15:0] best_time;

    modport slave (
        input  btn_press,
        input  clr_best,
        output go_led,
        output fail,
        output current_time,
        output best_time
    );

    modport master (
        output btn_press,
        output clr_best,
        input  go_led,
        input  fail,
        input  current_time,
        input  best_time
    );

endinterface

// File: rtl/reaction_game_ctrl_tick.sv
// Millisecond tick divider for the reaction-time game controller.
//   clk     : system clock (rising edge)
//   rst     : asynchronous active-high reset
//   restart : restart the divider from 0 on the next edge
//   tick    : high for one cycle every TICK_DIV cycles
module ms_tick_gen #(
    parameter int unsigned TICK_DIV = 100000
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    localparam int unsigned   CW   = $clog2(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        if (restart || (cnt_q == LAST)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // First tick after a restart arrives TICK_DIV cycles later.
    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/reaction_game_ctrl.sv
// Reaction-time game controller.
// The player starts a round, waits a pseudo-random 1000..3047 ms, then must
// press as fast as possible once go_led lights. Times are in ms, capped at
// MAX_MS; the best (lowest) time is kept until cleared.
//   clk : system clock (rising edge)
//   rst : asynchronous active-high reset
//   bus : reaction_game_ctrl_if.slave (btn_press, clr_best in;
//         go_led, fail, current_time, best_time out)
module reaction_game_ctrl
    import reaction_game_ctrl_pkg::*;
#(
    parameter int unsigned TICK_DIV = 100000,
    parameter int unsigned MAX_MS   = 9999
) (
    input  logic                 clk,
    input  logic                 rst,
    reaction_game_ctrl_if.slave  bus
);

    localparam logic [15:0] MAX_T = 16'(MAX_MS);

    state_e      state_q;
    logic        go_led_q;
    logic        fail_q;
    logic [15:0] cur_q;
    logic [15:0] best_q;
    logic [15:0] delay_q;
    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;
    logic [15:0] new_delay_d;

    logic btn;
    logic clr;
    logic ms_tick;
    logic wait_done;
    logic go_timeout;
    logic restart;

    assign btn = bus.btn_press;
    assign clr = bus.clr_best;

    assign lfsr_d      = lfsr_next(lfsr_q);
    assign new_delay_d = MIN_DELAY_MS + {5'b0, lfsr_q[10:0]};

    assign wait_done  = ms_tick && (delay_q == 16'd1);
    assign go_timeout = ms_tick && (cur_q == MAX_T);

    // Every btn_press changes state, as do the two tick-driven exits; the
    // divider is restarted on exactly those edges so each state starts at 0.
    always_comb begin
        restart = btn;
        if ((state_q == ST_WAIT) && wait_done) begin
            restart = 1'b1;
        end
        if ((state_q == ST_GO) && go_timeout) begin
            restart = 1'b1;
        end
    end

    ms_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk     (clk),
        .rst     (rst),
        .restart (restart),
        .tick    (ms_tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            go_led_q <= 1'b0;
            fail_q   <= 1'b0;
            cur_q    <= '0;
            best_q   <= NO_RECORD;
            delay_q  <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (btn) begin
                        state_q <= ST_WAIT;
                        delay_q <= new_delay_d;
                        cur_q   <= '0;
                    end
                end
                ST_WAIT: begin
                    // Early press beats a coincident expiry tick.
                    if (btn) begin
                        state_q <= ST_FAILED;
                        fail_q  <= 1'b1;
                    end else if (ms_tick) begin
                        delay_q <= delay_q - 16'd1;
                        if (wait_done) begin
                            state_q  <= ST_GO;
                            go_led_q <= 1'b1;
                        end
                    end
                end
                ST_GO: begin
                    // A press on a tick cycle freezes the pre-tick count.
                    if (btn) begin
                        state_q  <= ST_RESULT;
                        go_led_q <= 1'b0;
                        if (cur_q < best_q) begin
                            best_q <= cur_q;
                        end
                    end else if (ms_tick) begin
                        if (go_timeout) begin
                            state_q  <= ST_FAILED;
                            go_led_q <= 1'b0;
                            fail_q   <= 1'b1;
                        end else begin
                            cur_q <= cur_q + 16'd1;
                        end
                    end
                end
                ST_RESULT, ST_FAILED: begin
                    if (btn) begin
                        state_q <= ST_WAIT;
                        fail_q  <= 1'b0;
                        delay_q <= new_delay_d;
                        cur_q   <= '0;
                    end
                end
                default: begin
                    state_q  <= ST_IDLE;
                    go_led_q <= 1'b0;
                    fail_q   <= 1'b0;
                end
            endcase
            // Placed last so a clear overrides a same-edge record update.
            if (clr) begin
                best_q <= NO_RECORD;
            end
        end
    end

    assign bus.go_led       = go_led_q;
    assign bus.fail         = fail_q;
    assign bus.current_time = cur_q;
    assign bus.best_time    = best_q;

endmodule

// File: tb/tb_reaction_game_ctrl.sv
module tb_reaction_game_ctrl;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    reaction_game_ctrl_if bus_a ();
    reaction_game_ctrl_if bus_b ();

    reaction_game_ctrl #(
        .TICK_DIV (4),
        .MAX_MS   (9999)
    ) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    reaction_game_ctrl #(
        .TICK_DIV (2),
        .MAX_MS   (20)
    ) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference random source: the seeded maximal-length sequence
    // x^16+x^14+x^13+x^11+1, advanced once per clock, restarted by rst.
    logic [15:0] m_lfsr;
    always @(posedge clk or posedge rst) begin
        if (rst) m_lfsr <= 16'hACE1;
        else     m_lfsr <= (m_lfsr >> 1) |
                           (16'(((m_lfsr ^ (m_lfsr >> 2) ^ (m_lfsr >> 3) ^ (m_lfsr >> 5)) & 16'd1)) << 15);
    end

    // Reference best record for instance A.
    int unsigned m_best_a;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic press_a(input bit with_clr);
        bus_a.btn_press = 1'b1;
        bus_a.clr_best  = with_clr;
        cyc();
        bus_a.btn_press = 1'b0;
        bus_a.clr_best  = 1'b0;
    endtask

    // Wait (bounded) until the random source will yield a short delay.
    task automatic steer();
        for (int i = 0; i < 4000 && m_lfsr[10:0] >= 11'd48; i++) cyc();
    endtask

    // One full round on A. n = clock edges from the GO-entry edge to the
    // edge that samples the press; ticks land every 4 edges after GO entry,
    // so the frozen time is the number of ticks strictly before the press.
    task automatic round_a(input string tag, input int unsigned n, input bit with_clr);
        int unsigned dly;
        int unsigned waited;
        int unsigned exp_cur;
        steer();
        dly = 1000 + int'(m_lfsr[10:0]);
        press_a(1'b0);
        chk({tag, "/cur_cleared"}, bus_a.current_time, 0);
        chk({tag, "/delay_latched"}, dut_a.delay_q, dly);
        waited = 0;
        while (bus_a.go_led !== 1'b1 && waited < 13000) begin
            cyc();
            waited++;
        end
        chk({tag, "/wait_cycles"}, waited, 4 * dly);
        repeat (n - 1) cyc();
        chk({tag, "/go_before_press"}, bus_a.go_led, 1);
        press_a(with_clr);
        exp_cur = (n - 1) / 4;
        if (exp_cur > 9999) exp_cur = 9999;
        if (with_clr) m_best_a = 32'hFFFF;
        else if (exp_cur < m_best_a) m_best_a = exp_cur;
        chk({tag, "/cur"}, bus_a.current_time, exp_cur);
        chk({tag, "/best"}, bus_a.best_time, m_best_a);
        chk({tag, "/go_led"}, bus_a.go_led, 0);
        chk({tag, "/fail"}, bus_a.fail, 0);
    endtask

    initial begin
        int unsigned dly;
        int unsigned waited;
        int unsigned keep_cur;

        rst = 1'b1;
        bus_a.btn_press = 1'b0;
        bus_a.clr_best  = 1'b0;
        bus_b.btn_press = 1'b0;
        bus_b.clr_best  = 1'b0;
        m_best_a = 32'hFFFF;
        repeat (3) @(posedge clk);
        #1;
        chk("rst/go_led", bus_a.go_led, 0);
        chk("rst/fail", bus_a.fail, 0);
        chk("rst/cur", bus_a.current_time, 0);
        chk("rst/best", bus_a.best_time, 32'hFFFF);
        chk("rst/delay", dut_a.delay_q, 0);
        chk("rst/b_best", bus_b.best_time, 32'hFFFF);
        rst = 1'b0;
        cyc();

        // Timeout on B (TICK_DIV=2, MAX_MS=20): 21st tick in GO fails.
        steer();
        dly = 1000 + int'(m_lfsr[10:0]);
        bus_b.btn_press = 1'b1;
        cyc();
        bus_b.btn_press = 1'b0;
        waited = 0;
        while (bus_b.go_led !== 1'b1 && waited < 7000) begin
            cyc();
            waited++;
        end
        chk("tmo/wait_cycles", waited, 2 * dly);
        repeat (41) cyc();
        chk("tmo/pre_go", bus_b.go_led, 1);
        chk("tmo/pre_fail", bus_b.fail, 0);
        chk("tmo/pre_cur", bus_b.current_time, 20);
        cyc();
        chk("tmo/fail", bus_b.fail, 1);
        chk("tmo/go_led", bus_b.go_led, 0);
        chk("tmo/cur", bus_b.current_time, 20);
        chk("tmo/best", bus_b.best_time, 32'hFFFF);

        // Directed rounds on A: 250, 300, 120, 120 (tie).
        round_a("r250", 4 * 250 + 2, 1'b0);
        round_a("r300", 4 * 300 + 3, 1'b0);
        round_a("r120", 4 * 120 + 1, 1'b0);
        round_a("r120tie", 4 * 120 + 2, 1'b0);

        // Early press during WAIT.
        press_a(1'b0);
        repeat ($urandom_range(1, 3000)) cyc();
        chk("early/go_before", bus_a.go_led, 0);
        press_a(1'b0);
        chk("early/fail", bus_a.fail, 1);
        chk("early/go_led", bus_a.go_led, 0);
        chk("early/best", bus_a.best_time, m_best_a);
        chk("early/cur", bus_a.current_time, 0);

        // Press sampled on the 200th tick edge: pre-tick value 199.
        round_a("same_tick", 4 * 200, 1'b0);

        // Clear the record while sitting in RESULT.
        keep_cur = bus_a.current_time;
        bus_a.clr_best = 1'b1;
        cyc();
        bus_a.clr_best = 1'b0;
        m_best_a = 32'hFFFF;
        chk("clr/best", bus_a.best_time, m_best_a);
        chk("clr/cur_kept", bus_a.current_time, keep_cur);
        chk("clr/fail", bus_a.fail, 0);

        // Random response times; the second one clears on the update edge.
        round_a("rand1", $urandom_range(4, 1600), 1'b0);
        round_a("rand_clr", $urandom_range(4, 1600), 1'b1);
        round_a("rand3", $urandom_range(4, 1600), 1'b0);

        // Delay sampling over 50 rounds: start, check latch, fail early.
        for (int i = 0; i < 50; i++) begin
            repeat ($urandom_range(0, 15)) cyc();
            dly = 1000 + int'(m_lfsr[10:0]);
            press_a(1'b0);
            chk("dly/value", dut_a.delay_q, dly);
            chk("dly/range", (dut_a.delay_q >= 16'd1000) && (dut_a.delay_q <= 16'd3047), 1);
            repeat ($urandom_range(0, 15)) cyc();
            press_a(1'b0);
            chk("dly/early_fail", bus_a.fail, 1);
        end

        // Reset in the middle of GO.
        steer();
        press_a(1'b0);
        waited = 0;
        while (bus_a.go_led !== 1'b1 && waited < 13000) begin
            cyc();
            waited++;
        end
        repeat (100) cyc();
        chk("mid_rst/in_go", bus_a.go_led, 1);
        rst = 1'b1;
        #1;
        chk("mid_rst/go_led", bus_a.go_led, 0);
        chk("mid_rst/fail", bus_a.fail, 0);
        chk("mid_rst/cur", bus_a.current_time, 0);
        chk("mid_rst/best", bus_a.best_time, 32'hFFFF);
        chk("mid_rst/delay", dut_a.delay_q, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (10) cyc();
        chk("post_rst/go_led", bus_a.go_led, 0);
        chk("post_rst/best", bus_a.best_time, 32'hFFFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/reaction_game_ctrl.md
REACTION_GAME_CTRL -- requirements
Module: reaction_game_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 100000, meaning clk cycles per 1 ms tick; legal values are 2 or more.
REQ-002 SHALL have parameter MAX_MS, default 9999, meaning the reaction timeout in ms.
REQ-003 SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port btn_press, input, 1 bit: single-cycle pulse from the debounced player button.
REQ-006 SHALL have port clr_best, input, 1 bit: single-cycle pulse that erases the best record.
REQ-007 SHALL have port go_led, output, 1 bit: the "react now" stimulus.
REQ-008 SHALL have port fail, output, 1 bit: FAIL-state flag for the display.
REQ-009 SHALL have port current_time, output, 16 bits: last or running reaction time in ms.
REQ-010 SHALL have port best_time, output, 16 bits: best record in ms; 16'hFFFF means no record.

Function
REQ-011 SHALL implement the states IDLE, WAIT, GO, RESULT and FAILED.
REQ-012 SHALL generate a 1-cycle ms_tick every TICK_DIV clk cycles; the tick divider restarts from 0 on every state entry.
REQ-013 SHALL run a 16-bit maximal-length LFSR every clk cycle with a nonzero seed of 16'hACE1; the LFSR is never all-zero.
REQ-014 In IDLE, btn_press SHALL cause the following on the next edge: go to WAIT, latch delay_ms = 1000 + lfsr[10:0] (range 1000..3047), and clear current_time to 0.
REQ-015 In WAIT, each ms_tick SHALL decrement delay_ms; when delay_ms reaches 0, the block SHALL go to GO on that edge.
REQ-016 In WAIT, btn_press SHALL have priority over tick expiry and send the block to FAILED (early press).
REQ-017 In GO, go_led SHALL be 1 and each ms_tick SHALL increment current_time.
REQ-018 In GO, btn_press SHALL go to RESULT, freezing current_time; a btn_press arriving in the same cycle as a tick SHALL freeze the value before that tick's increment.
REQ-019 In GO, when current_time = MAX_MS and an ms_tick occurs, the block SHALL go to FAILED with current_time held at MAX_MS.
REQ-020 On entry to RESULT, if current_time < best_time, best_time SHALL load current_time; ties SHALL NOT update.
REQ-021 In RESULT and FAILED, btn_press SHALL go to WAIT, applying the same actions as REQ-014.
REQ-022 fail SHALL be 1 exactly while in FAILED; go_led SHALL be 1 exactly while in GO; both outputs SHALL be registered.
REQ-023 clr_best SHALL set best_time to 16'hFFFF in any state; if clr_best coincides with a best_time update, clr_best SHALL win.
REQ-024 current_time SHALL never exceed MAX_MS, so it always fits four decimal digits.

Reset
REQ-025 rst SHALL asynchronously force: state = IDLE, go_led = 0, fail = 0, current_time = 0, best_time = 16'hFFFF, LFSR = seed, tick divider = 0 and delay_ms = 0.
REQ-026 Asserting rst mid-round (WAIT or GO) SHALL abandon the round with no best_time update.

Structure
REQ-027 A shared package SHALL hold the state enum, NO_RECORD = 16'hFFFF, MIN_DELAY_MS = 1000 and LFSR_SEED; TICK_DIV and MAX_MS remain module parameters.
REQ-028 The ms tick divider SHALL be a sub-module named ms_tick_gen, with ports clk, rst, restart and tick.

Verification
REQ-029 With TICK_DIV = 4, rst then btn_press, wait for go_led, then btn_press after 250 ticks -> RESULT, current_time = 250, best_time = 250, fail = 0.
REQ-030 Play a second round with a response of 300 ticks, then a third with 120 -> best_time stays 250, then becomes 120; play a fourth round with 120 -> best_time stays 120 (tie).
REQ-031 btn_press during WAIT, before go_led -> FAILED, fail = 1, go_led = 0, best_time unchanged.
REQ-032 With MAX_MS = 20, no press in GO -> on the 21st tick the state becomes FAILED with current_time = 20.
REQ-033 Pulse clr_best while in RESULT with best_time = 120 -> best_time = 16'hFFFF; assert rst during GO -> all outputs immediately take their reset values per REQ-025.
REQ-034 Press btn_press on the same cycle as an ms_tick in GO -> current_time equals the pre-tick count (per REQ-018); sample delay_ms over 50 rounds -> every value lies in 1000..3047.
